// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU for the EX stage.
// The multiplier is a shift-add unit that takes one bit per cycle, LSB first.
// The divider is restoring and produces one quotient bit per cycle, MSB first.
// Both run on operand magnitudes, and the result signs are fixed up on the
// final iteration. The result goes out on a registered HI/LO write port as a
// one-cycle pulse.
// Optional build macro MDU_FAST_MUL_EN: multiplies complete in a single cycle
// through a combinational multiplier. Divides are unchanged.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd;      // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] acc;       // product accumulator / low half = dividend->quotient
    logic [WIDTH:0]     rem;       // partial remainder
    logic               neg_res;   // operand signs differ (signed ops)
    logic               neg_rem;   // dividend negative (signed ops)
    logic               dz;        // divide by zero

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod;
    logic [WIDTH:0]     div_shift, div_rem_next;
    logic               div_ge;
    logic [WIDTH-1:0]   div_q_next, quo, rmd, res_hi, res_lo;
    logic               is_mul;
`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;
`endif

    // Pipeline hold: accepted start cycle plus every iteration cycle
    assign stall = ((state == IDLE) & start & ~flush) | (state == BUSY);

    // Operand magnitudes and signs for the op being issued
    always_comb begin
        sa    = ~op[0] & src_a[WIDTH-1];
        sb    = ~op[0] & src_b[WIDTH-1];
        mag_a = sa ? -src_a : src_a;
        mag_b = sb ? -src_b : src_b;
`ifdef MDU_FAST_MUL_EN
        fast_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_prod = (sa ^ sb) ? -fast_mag : fast_mag;
`endif
    end

    // One iteration step of each datapath, plus sign fix-up of the final step
    always_comb begin
        is_mul       = ~op_q[1];
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next     = {mul_sum, acc[WIDTH-1:1]};
        div_shift    = {rem[WIDTH-1:0], acc[WIDTH-1]};
        div_ge       = div_shift >= {1'b0, opnd};
        div_rem_next = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;
        div_q_next   = {acc[WIDTH-2:0], div_ge};
        prod         = neg_res ? -mul_next : mul_next;
        quo          = dz ? '1 : (neg_res ? -div_q_next : div_q_next);
        rmd          = neg_rem ? -div_rem_next[WIDTH-1:0] : div_rem_next[WIDTH-1:0];
        res_hi       = is_mul ? prod[2*WIDTH-1:WIDTH] : rmd;
        res_lo       = is_mul ? prod[WIDTH-1:0] : quo;
    end

    // Control FSM, iteration registers and the registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            opnd     <= '0;
            acc      <= '0;
            rem      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            done     <= 1'b0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
        end else begin
            // write port is a pulse: cleared unless set below
            done     <= 1'b0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (start) begin
                            op_q    <= op;
                            neg_res <= sa ^ sb;
                            neg_rem <= sa;
                            dz      <= (src_b == '0);
                            rem     <= '0;
                            if (op[1]) begin
                                opnd <= mag_b;
                                acc  <= {{WIDTH{1'b0}}, mag_a};
                            end else begin
                                opnd <= mag_a;
                                acc  <= {{WIDTH{1'b0}}, mag_b};
                            end
`ifdef MDU_FAST_MUL_EN
                            if (!op[1]) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                hi_we    <= 1'b1;
                                lo_we    <= 1'b1;
                                hi_wdata <= fast_prod[2*WIDTH-1:WIDTH];
                                lo_wdata <= fast_prod[WIDTH-1:0];
                            end else begin
                                state <= BUSY;
                            end
`else
                            state <= BUSY;
`endif
                        end
                    end
                    BUSY: begin
                        cnt <= cnt + 1'b1;
                        if (is_mul) begin
                            acc <= mul_next;
                        end else begin
                            acc <= {acc[2*WIDTH-1:WIDTH], div_q_next};
                            rem <= div_rem_next;
                        end
                        if (cnt == CW'(WIDTH - 1)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            hi_we    <= 1'b1;
                            lo_we    <= 1'b1;
                            hi_wdata <= res_hi;
                            lo_wdata <= res_lo;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus hand-written flush, ignored-start
// and reset sequences for mul_div_unit.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, done, hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int n_pass = 0;
    int n_total = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .stall(stall), .done(done),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        string       nm;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return 33;
    endfunction

    // Called right after a negedge; returns right after a negedge.
    task automatic run_vec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        int n;
        bit stall_ok;
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1 chk({nm, " stall@start"}, 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        stall_ok = 1'b1;
        while (!done && n < 100) begin
            if (!stall) stall_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(exp_lat(o)));
        chk({nm, " stall busy"}, 64'(stall_ok), 64'd1);
        chk({nm, " stall@done"}, 64'(stall), 64'd0);
        chk({nm, " we"}, {62'd0, hi_we, lo_we}, 64'd3);
        chk({nm, " hi"}, 64'(hi_wdata), 64'(ehi));
        chk({nm, " lo"}, 64'(lo_wdata), 64'(elo));
        @(negedge clk);
        chk({nm, " pulse end"}, {61'd0, done, hi_we, lo_we}, 64'd0);
    endtask

    initial begin
        int n;
        bit bad;
        vecs[0]  = '{2'b10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
        vecs[1]  = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, "divu big/16"};
        vecs[2]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div ovf"};
        vecs[3]  = '{2'b00, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, "mult -1*2"};
        vecs[4]  = '{2'b01, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, "multu max*2"};
        vecs[5]  = '{2'b11, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, "divu by 0"};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
        vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min"};
        vecs[8]  = '{2'b00, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult 3*-5"};
        vecs[9]  = '{2'b01, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, "multu shift"};
        vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div -7 by 0"};
        vecs[11] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       "divu 100/7"};

        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {stall, done, hi_we, lo_we, hi_wdata, lo_wdata}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].nm);

        // flush at cycle 10, then a new op issued at cycle 11
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) flush = 1'b1;
            #1 if (!stall || done) bad = 1'b1;
            @(negedge clk);
        end
        flush = 1'b0;
        #1 chk("flush stall drop", 64'(stall), 64'd0);
        chk("flush busy window", 64'(bad), 64'd0);
        chk("flush no write", {61'd0, done, hi_we, lo_we}, 64'd0);
        run_vec(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "after flush");

        // start pulsed mid-op with other operands is ignored
        op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (n == 5) begin
                op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("ignored start latency", 64'(n), 64'd33);
        chk("ignored start result", {hi_wdata, lo_wdata}, {32'd1, 32'd333});
        @(negedge clk);

        // synchronous reset at cycle 20 aborts without a write
        op = 2'b10; src_a = 32'h0000FFFF; src_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid-op outputs", {stall, done, hi_we, lo_we, hi_wdata, lo_wdata}, '0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || hi_we || lo_we || stall) bad = 1'b1;
        end
        chk("rst mid-op no write", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
